// File: rtl/mux_n_pipe_pkg.sv
// Shared types and constants for the mux_n_pipe selector: occupancy states,
// error-counter width and the select-width helper.
package mux_n_pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // A two-input selector still needs one select bit, so the width never drops below 1.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// Upstream/downstream handshake bundle for mux_n_pipe.
// err_cnt exists only when MUX_N_PIPE_ERR_CNT_EN is defined.
interface mux_n_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) ();
    import mux_n_pipe_pkg::*;

    localparam int SEL_W = sel_width(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_sel;
`ifdef MUX_N_PIPE_ERR_CNT_EN
    logic [ERR_CNT_W-1:0]    err_cnt;
`endif

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid,
`ifdef MUX_N_PIPE_ERR_CNT_EN
        input  err_cnt,
`endif
        input  err_sel
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid,
`ifdef MUX_N_PIPE_ERR_CNT_EN
        output err_cnt,
`endif
        output err_sel
    );

endinterface

// File: rtl/mux_n_comb.sv
// Pure N-way indexed select; an index with no matching input yields zero
// data and raises o_bad.
module mux_n_comb
    import mux_n_pipe_pkg::*;
#(
    parameter int   WIDTH  = 32,
    parameter int   NUM_IN = 4,
    localparam int  SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_bad
);

    logic [NUM_IN-1:0] w_hit;

    // AND-OR select over a one-hot match vector; no match leaves the data at zero
    always_comb begin
        o_data = {WIDTH{1'b0}};
        w_hit  = {NUM_IN{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            w_hit[k] = (i_sel == SEL_W'(k));
            o_data   = o_data | ({WIDTH{w_hit[k]}} & i_data[k*WIDTH +: WIDTH]);
        end
        o_bad = ~|w_hit;
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way registered selector with valid/ready on both sides and a skid register
// behind the output stage. MUX_N_PIPE_ERR_CNT_EN adds a saturating bad-select counter.
module mux_n_pipe
    import mux_n_pipe_pkg::*;
#(
    parameter int   WIDTH  = 32,
    parameter int   NUM_IN = 4,
    localparam int  SEL_W  = sel_width(NUM_IN)
) (
    input logic         clk,
    input logic         reset,
    mux_n_pipe_if.slave bus
);

    if ((NUM_IN < 2) || (NUM_IN > 16)) begin : g_num_in_check
        $error("mux_n_pipe: NUM_IN must be within 2..16");
    end

    occ_state_e       r_state;
    occ_state_e       w_next_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_err_sel;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic [WIDTH-1:0] r_skid_data;
    logic [SEL_W-1:0] r_skid_sel;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_bad;
    logic             w_accept;
    logic             w_consume;
    logic             w_load_in;
    logic             w_load_skid;
    logic             w_skid_to_out;

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .i_data (bus.in_data),
        .i_sel  (bus.in_sel),
        .o_data (w_sel_data),
        .o_bad  (w_bad)
    );

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_consume = r_out_valid & bus.out_ready;

    // Occupancy next-state and datapath steering
    always_comb begin
        w_next_state  = r_state;
        w_load_in     = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_next_state = OCC_ONE;
                    w_load_in    = 1'b1;
                end else begin
                    w_next_state = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (w_accept && w_consume) begin
                    w_next_state = OCC_ONE;
                    w_load_in    = 1'b1;
                end else if (w_accept) begin
                    w_next_state = OCC_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_consume) begin
                    w_next_state = OCC_EMPTY;
                end else begin
                    w_next_state = OCC_ONE;
                end
            end
            OCC_FULL: begin
                if (w_consume) begin
                    w_next_state  = OCC_ONE;
                    w_skid_to_out = 1'b1;
                end else begin
                    w_next_state = OCC_FULL;
                end
            end
            default: begin
                w_next_state = OCC_EMPTY;
            end
        endcase
    end

    // State, handshake flags, output register and skid register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= OCC_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_out_sel   <= {SEL_W{1'b0}};
            r_skid_data <= {WIDTH{1'b0}};
            r_skid_sel  <= {SEL_W{1'b0}};
        end else begin
            r_state     <= w_next_state;
            // Flags follow the next state so in_ready never depends on out_ready combinationally
            r_in_ready  <= (w_next_state != OCC_FULL);
            r_out_valid <= (w_next_state != OCC_EMPTY);
            if (w_load_in) begin
                r_out_data <= w_sel_data;
                r_out_sel  <= bus.in_sel;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
                r_out_sel  <= r_skid_sel;
            end
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
                r_skid_sel  <= bus.in_sel;
            end
        end
    end

    // Sticky bad-select flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_sel <= 1'b0;
        end else if (w_accept && w_bad) begin
            r_err_sel <= 1'b1;
        end
    end

`ifdef MUX_N_PIPE_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating count of accepted bad-select beats
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= {ERR_CNT_W{1'b0}};
        end else if (w_accept && w_bad && (r_err_cnt != ERR_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.err_sel   = r_err_sel;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: three instances (4x32, 3x32, 5x16) with
// directed vectors plus a randomised handshake stream on the 5x16 instance.
module tb_mux_n_pipe;
    import mux_n_pipe_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    mux_n_pipe_if #(.WIDTH(32), .NUM_IN(4)) a_if ();
    mux_n_pipe_if #(.WIDTH(32), .NUM_IN(3)) b_if ();
    mux_n_pipe_if #(.WIDTH(16), .NUM_IN(5)) c_if ();

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
    mux_n_pipe #(.WIDTH(32), .NUM_IN(3)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));
    mux_n_pipe #(.WIDTH(16), .NUM_IN(5)) u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

    logic [33:0] q_a [$];
    logic [33:0] q_b [$];
    logic [18:0] q_c [$];
    logic        c_hold  = 1'b0;
    logic [18:0] c_saved = 19'd0;

    logic [1:0] seq1 [5] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] seqb [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    function automatic logic [31:0] exp_a(input logic [1:0] s);
        case (s)
            2'd0:    return 32'h11;
            2'd1:    return 32'h22;
            2'd2:    return 32'h33;
            default: return 32'h44;
        endcase
    endfunction

    function automatic logic [31:0] exp_b(input logic [1:0] s);
        case (s)
            2'd0:    return 32'hA1;
            2'd1:    return 32'hB2;
            2'd2:    return 32'hC3;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [15:0] exp_c(input logic [2:0] s);
        case (s)
            3'd0:    return 16'h1111;
            3'd1:    return 16'h2222;
            3'd2:    return 16'h3333;
            3'd3:    return 16'h4444;
            3'd4:    return 16'h5555;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic extra_beat(input string name, input logic [63:0] act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got beat %0h with no beat expected at %0t", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Scoreboard for instance A: pop on consume, push on accept
    always @(negedge clk) begin
        if (reset) begin
            q_a.delete();
        end else begin
            if (a_if.out_valid && a_if.out_ready) begin
                if (q_a.size() == 0) extra_beat("a_extra", 64'({a_if.out_sel, a_if.out_data}));
                else chk("a_beat", 64'({a_if.out_sel, a_if.out_data}), 64'(q_a.pop_front()));
            end
            if (a_if.in_valid && a_if.in_ready) q_a.push_back({a_if.in_sel, exp_a(a_if.in_sel)});
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin
        if (reset) begin
            q_b.delete();
        end else begin
            if (b_if.out_valid && b_if.out_ready) begin
                if (q_b.size() == 0) extra_beat("b_extra", 64'({b_if.out_sel, b_if.out_data}));
                else chk("b_beat", 64'({b_if.out_sel, b_if.out_data}), 64'(q_b.pop_front()));
            end
            if (b_if.in_valid && b_if.in_ready) q_b.push_back({b_if.in_sel, exp_b(b_if.in_sel)});
        end
    end

    // Scoreboard for instance C, plus hold-stability of a stalled output
    always @(negedge clk) begin
        if (reset) begin
            q_c.delete();
            c_hold <= 1'b0;
        end else begin
            if (c_hold) begin
                chk("c_hold_valid", 64'(c_if.out_valid), 64'd1);
                chk("c_hold_stable", 64'({c_if.out_sel, c_if.out_data}), 64'(c_saved));
            end
            if (c_if.out_valid && c_if.out_ready) begin
                if (q_c.size() == 0) extra_beat("c_extra", 64'({c_if.out_sel, c_if.out_data}));
                else chk("c_beat", 64'({c_if.out_sel, c_if.out_data}), 64'(q_c.pop_front()));
            end
            if (c_if.in_valid && c_if.in_ready) q_c.push_back({c_if.in_sel, exp_c(c_if.in_sel)});
            c_hold  <= c_if.out_valid && !c_if.out_ready;
            c_saved <= {c_if.out_sel, c_if.out_data};
        end
    end

    initial begin
        a_if.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        b_if.in_data = {32'hC3, 32'hB2, 32'hA1};
        c_if.in_data = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        a_if.in_sel = 2'd0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
        b_if.in_sel = 2'd0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
        c_if.in_sel = 3'd0; c_if.in_valid = 1'b0; c_if.out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        at_neg();
        chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst_in_ready", 64'(a_if.in_ready), 64'd1);
        chk("rst_out_data", 64'(a_if.out_data), 64'd0);
        chk("rst_out_sel", 64'(a_if.out_sel), 64'd0);
        chk("rst_err_sel", 64'(a_if.err_sel), 64'd0);
        chk("rst_c_out_valid", 64'(c_if.out_valid), 64'd0);

        // Latency and sustained stream sel 2,0,1,2,3
        for (int i = 0; i <= 5; i++) begin
            tick();
            if (i < 5) begin
                a_if.in_valid = 1'b1; a_if.in_sel = seq1[i]; a_if.out_ready = 1'b1;
            end else begin
                a_if.in_valid = 1'b0;
            end
            if (i > 0) begin
                at_neg();
                chk("t1_out_valid", 64'(a_if.out_valid), 64'd1);
                chk("t1_out", 64'({a_if.out_sel, a_if.out_data}), 64'({seq1[i-1], exp_a(seq1[i-1])}));
                chk("t1_in_ready", 64'(a_if.in_ready), 64'd1);
            end
        end
        tick(); at_neg();
        chk("t1_drained", 64'(a_if.out_valid), 64'd0);

        // Fill to FULL with out_ready low, hold a third beat, then drain
        tick(); a_if.in_valid = 1'b1; a_if.in_sel = 2'd1; a_if.out_ready = 1'b0;
        tick(); a_if.in_sel = 2'd3;
        at_neg();
        chk("t2_one_in_ready", 64'(a_if.in_ready), 64'd1);
        chk("t2_one_out", 64'({a_if.out_valid, a_if.out_sel, a_if.out_data}), {29'd0, 1'b1, 2'd1, 32'h22});
        tick(); a_if.in_sel = 2'd0;
        at_neg();
        chk("t2_full_in_ready", 64'(a_if.in_ready), 64'd0);
        chk("t2_full_out", 64'({a_if.out_sel, a_if.out_data}), {30'd0, 2'd1, 32'h22});
        tick(); at_neg();
        chk("t2_full_hold_ready", 64'(a_if.in_ready), 64'd0);
        chk("t2_full_hold_out", 64'({a_if.out_valid, a_if.out_data}), {31'd0, 1'b1, 32'h22});
        tick(); a_if.out_ready = 1'b1;
        at_neg();
        chk("t2_pre_drain", 64'(a_if.out_data), 64'h22);
        tick(); at_neg();
        chk("t2_skid_out", 64'({a_if.out_valid, a_if.out_sel, a_if.out_data}), {29'd0, 1'b1, 2'd3, 32'h44});
        chk("t2_skid_in_ready", 64'(a_if.in_ready), 64'd1);
        tick(); a_if.in_valid = 1'b0;
        at_neg();
        chk("t2_third_out", 64'({a_if.out_valid, a_if.out_sel, a_if.out_data}), {29'd0, 1'b1, 2'd0, 32'h11});
        tick(); at_neg();
        chk("t2_empty", 64'(a_if.out_valid), 64'd0);

        // Reset while FULL
        tick(); a_if.in_valid = 1'b1; a_if.in_sel = 2'd1; a_if.out_ready = 1'b0;
        tick(); a_if.in_sel = 2'd2;
        tick(); a_if.in_valid = 1'b0;
        at_neg();
        chk("t4_full_in_ready", 64'(a_if.in_ready), 64'd0);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        at_neg();
        chk("t4_rst_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("t4_rst_in_ready", 64'(a_if.in_ready), 64'd1);
        chk("t4_rst_out", 64'({a_if.out_sel, a_if.out_data}), 64'd0);
        chk("t4_rst_err_sel", 64'(a_if.err_sel), 64'd0);
        tick(); a_if.in_valid = 1'b1; a_if.in_sel = 2'd3; a_if.out_ready = 1'b1;
        tick(); a_if.in_valid = 1'b0;
        at_neg();
        chk("t4_post_out", 64'({a_if.out_valid, a_if.out_sel, a_if.out_data}), {29'd0, 1'b1, 2'd3, 32'h44});
        tick(); at_neg();
        chk("t4_post_empty", 64'(a_if.out_valid), 64'd0);

        // Out-of-range select on the 3-input instance
        tick(); b_if.out_ready = 1'b1;
        at_neg();
        chk("t3_err_clear", 64'(b_if.err_sel), 64'd0);
        tick(); b_if.in_valid = 1'b1; b_if.in_sel = 2'd3;
        tick(); b_if.in_sel = seqb[0];
        at_neg();
        chk("t3_bad_out", 64'({b_if.out_valid, b_if.out_sel, b_if.out_data}), {29'd0, 1'b1, 2'd3, 32'h0});
        chk("t3_err_set", 64'(b_if.err_sel), 64'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i < 5) b_if.in_sel = seqb[i];
            else b_if.in_valid = 1'b0;
            at_neg();
            chk("t3_good_out", 64'({b_if.out_sel, b_if.out_data}), 64'({seqb[i-1], exp_b(seqb[i-1])}));
            chk("t3_err_sticky", 64'(b_if.err_sel), 64'd1);
        end
`ifdef MUX_N_PIPE_ERR_CNT_EN
        chk("t3_err_cnt_one", 64'(b_if.err_cnt), 64'd1);
`endif
        tick(); b_if.in_valid = 1'b1; b_if.in_sel = 2'd3;
        repeat (300) tick();
        b_if.in_valid = 1'b0;
        tick(); at_neg();
        chk("t3_err_after_stream", 64'(b_if.err_sel), 64'd1);
`ifdef MUX_N_PIPE_ERR_CNT_EN
        chk("t3_err_cnt_sat", 64'(b_if.err_cnt), 64'd255);
`endif

        // Random handshake stream on the 5-input instance
        for (int i = 0; i < 10000; i++) begin
            tick();
            c_if.in_valid  = 1'($urandom_range(0, 1));
            c_if.out_ready = 1'($urandom_range(0, 1));
            c_if.in_sel    = 3'($urandom_range(0, 7));
        end
        tick(); c_if.in_valid = 1'b0; c_if.out_ready = 1'b1;
        repeat (4) tick();
        at_neg();
        chk("c_drained", 64'(q_c.size()), 64'd0);
        chk("c_out_idle", 64'(c_if.out_valid), 64'd0);
        chk("c_err_sel", 64'(c_if.err_sel), 64'd1);
        chk("a_drained", 64'(q_a.size()), 64'd0);
        chk("b_drained", 64'(q_b.size()), 64'd0);
        chk("a_err_never", 64'(a_if.err_sel), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
